// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU/VRAM widths, video timing constants and write-FSM state type
package gpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // 264 clocks per line x 628 lines per frame
  localparam int H_TOTAL    = 264;
  localparam int V_TOTAL    = 628;
  localparam int H_ACTIVE   = 200;
  localparam int V_ACTIVE   = 600;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } vram_wr_state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - GPU, CPU and SRAM pin bundle around the VRAM arbiter
interface vram_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = gpu_pkg::ADDR_W,
  parameter int DATA_W = gpu_pkg::DATA_W
);
  import gpu_pkg::*;

  localparam int CNT_W = cnt_w(DEPTH);

  logic [ADDR_W-1:0] gpuAddr;
  logic              gpuOe;
  logic              cpuValid;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuData;
  logic              cpuReady;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDout;
  logic              ramDrive;
  logic              ramWe;
  logic              ramOe;
  logic [CNT_W-1:0]  fifoCount;
  logic              busy;

  modport slave (
    input  gpuAddr, gpuOe, cpuValid, cpuAddr, cpuData,
    output cpuReady, ramAddr, ramDout, ramDrive, ramWe, ramOe, fifoCount, busy
  );

  modport master (
    output gpuAddr, gpuOe, cpuValid, cpuAddr, cpuData,
    input  cpuReady, ramAddr, ramDout, ramDrive, ramWe, ramOe, fifoCount, busy
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - CPU write buffer, DEPTH entries of {addr, data}, power-of-two depth
module vram_wr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares video SRAM: zero-latency GPU reads, buffered CPU writes drained in blanking
module vram_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = gpu_pkg::ADDR_W,
  parameter int DATA_W = gpu_pkg::DATA_W
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);
  import gpu_pkg::*;

  localparam int W     = ADDR_W + DATA_W;
  localparam int CNT_W = cnt_w(DEPTH);

  vram_wr_state_t    state;
  logic              drive_q;
  logic              we_q;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  logic [W-1:0]      head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              have_work;

  assign {head_addr, head_data} = head;
  assign push      = bus.cpuValid && !full;
  assign pop       = (state == WR_STROBE) && !bus.gpuOe;
  // An entry arriving this cycle lets IDLE start SETUP without waiting a cycle
  assign have_work = !empty || push;

  vram_wr_fifo #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({bus.cpuAddr, bus.cpuData}),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WR_IDLE;
      drive_q   <= 1'b0;
      we_q      <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      case (state)
        WR_IDLE: begin
          we_q <= 1'b0;
          if (have_work && !bus.gpuOe) begin
            state   <= WR_SETUP;
            drive_q <= 1'b1;
          end else begin
            drive_q <= 1'b0;
          end
        end
        WR_SETUP: begin
          if (bus.gpuOe) begin
            state   <= WR_IDLE;
            drive_q <= 1'b0;
            we_q    <= 1'b0;
          end else begin
            state   <= WR_STROBE;
            drive_q <= 1'b1;
            we_q    <= 1'b1;
          end
        end
        WR_STROBE: begin
          we_q <= 1'b0;
          // An abort leaves the head in the FIFO so the whole cycle is retried
          if (bus.gpuOe) begin
            state   <= WR_IDLE;
            drive_q <= 1'b0;
          end else begin
            state     <= WR_HOLD;
            drive_q   <= 1'b1;
            hold_addr <= head_addr;
            hold_data <= head_data;
          end
        end
        WR_HOLD: begin
          we_q <= 1'b0;
          if (have_work && !bus.gpuOe) begin
            state   <= WR_SETUP;
            drive_q <= 1'b1;
          end else begin
            state   <= WR_IDLE;
            drive_q <= 1'b0;
          end
        end
        default: begin
          state   <= WR_IDLE;
          drive_q <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  // GPU ownership overrides everything combinationally, including during reset
  assign bus.ramOe     = bus.gpuOe;
  assign bus.ramAddr   = bus.gpuOe ? bus.gpuAddr
                       : ((state == WR_HOLD) ? hold_addr : head_addr);
  assign bus.ramDout   = (state == WR_HOLD) ? hold_data : head_data;
  assign bus.ramWe     = we_q && !bus.gpuOe;
  assign bus.ramDrive  = drive_q && !bus.gpuOe;
  assign bus.cpuReady  = !full;
  assign bus.fifoCount = count;
  assign bus.busy      = !empty || (state != WR_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed and randomized bench for vram_arbiter with a queue/array SRAM model
module tb_vram_arbiter;
  import gpu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vram_arbiter_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t               exp_q[$];
  logic [DATA_W-1:0] exp_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ram_mem [logic [ADDR_W-1:0]];

  int checks;
  int errors;
  int cyc_n;
  int wr_count;
  int last_wr_cyc;
  int start;
  int wr0;
  int first_wr;
  int line;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // Per-cycle monitor: pending queue is the model FIFO, every strobe must retire its head
  task automatic tick();
    logic ready_exp;
    ready_exp = (exp_q.size() != DEPTH);
    chk("fifo_count", 32'(bus.fifoCount), 32'(exp_q.size()));
    chk("cpu_ready", 32'(bus.cpuReady), 32'(ready_exp));
    if (exp_q.size() != 0) chk("busy_pending", 32'(bus.busy), 32'd1);
    if (bus.ramWe === 1'b1) begin
      chk("we_while_gpu", 32'(bus.gpuOe), 32'd0);
      chk("drive_with_we", 32'(bus.ramDrive), 32'd1);
      chk("write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("wr_addr", 32'(bus.ramAddr), 32'(exp_q[0].a));
        chk("wr_data", 32'(bus.ramDout), 32'(exp_q[0].d));
        void'(exp_q.pop_front());
      end
      ram_mem[bus.ramAddr] = bus.ramDout;
      wr_count++;
      last_wr_cyc = cyc_n;
    end
    if (bus.cpuValid && ready_exp) begin
      exp_q.push_back('{a: bus.cpuAddr, d: bus.cpuData});
      exp_mem[bus.cpuAddr] = bus.cpuData;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc_n = 0; wr_count = 0; last_wr_cyc = -1;
    rst = 1'b1;
    bus.gpuOe = 1'b0; bus.gpuAddr = '0;
    bus.cpuValid = 1'b0; bus.cpuAddr = '0; bus.cpuData = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    settle();
    chk("rst_we", 32'(bus.ramWe), 32'd0);
    chk("rst_drive", 32'(bus.ramDrive), 32'd0);
    chk("rst_ready", 32'(bus.cpuReady), 32'd1);
    chk("rst_count", 32'(bus.fifoCount), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    bus.gpuOe = 1'b1; bus.gpuAddr = 16'hBEEF;
    #1;
    chk("rst_oe", 32'(bus.ramOe), 32'd1);
    chk("rst_addr", 32'(bus.ramAddr), 32'hBEEF);
    bus.gpuOe = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single write in blanking
    bus.cpuValid = 1'b1; bus.cpuAddr = 16'h1234; bus.cpuData = 8'hA5;
    settle(); tick();
    bus.cpuValid = 1'b0;
    settle();
    chk("s_setup_drive", 32'(bus.ramDrive), 32'd1);
    chk("s_setup_we", 32'(bus.ramWe), 32'd0);
    tick();
    settle();
    chk("s_strobe_we", 32'(bus.ramWe), 32'd1);
    chk("s_strobe_addr", 32'(bus.ramAddr), 32'h1234);
    chk("s_strobe_data", 32'(bus.ramDout), 32'hA5);
    tick();
    settle();
    chk("s_hold_we", 32'(bus.ramWe), 32'd0);
    chk("s_hold_drive", 32'(bus.ramDrive), 32'd1);
    chk("s_hold_addr", 32'(bus.ramAddr), 32'h1234);
    tick();
    settle();
    chk("s_idle_drive", 32'(bus.ramDrive), 32'd0);
    chk("s_idle_busy", 32'(bus.busy), 32'd0);
    tick();

    // fill under GPU ownership, fifth write back-pressured
    bus.gpuOe = 1'b1; bus.gpuAddr = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      bus.cpuValid = 1'b1;
      bus.cpuAddr = ADDR_W'(16'h2000 + i);
      bus.cpuData = DATA_W'(8'h10 + i);
      settle();
      chk("fill_no_we", 32'(bus.ramWe), 32'd0);
      if (i == 4) begin
        chk("fill_ready", 32'(bus.cpuReady), 32'd0);
        chk("fill_count", 32'(bus.fifoCount), 32'd4);
      end
      tick();
      bus.gpuAddr = bus.gpuAddr + 16'd1;
    end
    bus.cpuValid = 1'b0; bus.gpuOe = 1'b0;
    start = cyc_n; wr0 = wr_count; first_wr = -1;
    repeat (14) begin
      settle();
      if (bus.ramWe === 1'b1 && first_wr < 0) first_wr = cyc_n - start;
      tick();
    end
    chk("drain_writes", 32'(wr_count - wr0), 32'd4);
    chk("drain_first", 32'(first_wr), 32'd2);
    chk("drain_last", 32'(last_wr_cyc - start), 32'd11);

    // abort during STROBE, then retry once
    bus.cpuValid = 1'b1; bus.cpuAddr = 16'h0042; bus.cpuData = 8'h3C;
    settle(); tick();
    bus.cpuValid = 1'b0;
    settle();
    chk("ab_setup_drive", 32'(bus.ramDrive), 32'd1);
    tick();
    bus.gpuOe = 1'b1; bus.gpuAddr = 16'h7777;
    settle();
    chk("ab_we", 32'(bus.ramWe), 32'd0);
    chk("ab_addr", 32'(bus.ramAddr), 32'h7777);
    chk("ab_count", 32'(bus.fifoCount), 32'd1);
    tick();
    repeat (3) begin
      settle();
      chk("ab_wait_count", 32'(bus.fifoCount), 32'd1);
      tick();
    end
    bus.gpuOe = 1'b0; wr0 = wr_count;
    repeat (6) begin
      settle(); tick();
    end
    chk("ab_rewrites", 32'(wr_count - wr0), 32'd1);
    chk("ab_count_end", 32'(bus.fifoCount), 32'd0);

    // push and pop in the same cycle
    bus.gpuOe = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.cpuValid = 1'b1;
      bus.cpuAddr = ADDR_W'(16'h3000 + i);
      bus.cpuData = DATA_W'(8'h60 + i);
      settle(); tick();
    end
    bus.cpuValid = 1'b0; bus.gpuOe = 1'b0;
    settle(); tick();
    settle(); tick();
    bus.cpuValid = 1'b1; bus.cpuAddr = 16'h3002; bus.cpuData = 8'h62;
    settle();
    chk("pp_strobe_we", 32'(bus.ramWe), 32'd1);
    chk("pp_count_before", 32'(bus.fifoCount), 32'd2);
    tick();
    bus.cpuValid = 1'b0;
    settle();
    chk("pp_count_after", 32'(bus.fifoCount), 32'd2);
    tick();
    repeat (10) begin
      settle(); tick();
    end

    // reset in the middle of a write strobe
    bus.cpuValid = 1'b1; bus.cpuAddr = 16'h4000; bus.cpuData = 8'h99;
    settle(); tick();
    bus.cpuValid = 1'b0;
    settle(); tick();
    settle();
    chk("rm_strobe_we", 32'(bus.ramWe), 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_we", 32'(bus.ramWe), 32'd0);
    chk("rm_drive", 32'(bus.ramDrive), 32'd0);
    chk("rm_count", 32'(bus.fifoCount), 32'd0);
    exp_q.delete();
    exp_mem.delete();
    ram_mem.delete();
    tick();
    rst = 1'b0;

    // randomized CPU traffic across vertical blanking and active lines
    for (int l = 0; l < 68; l++) begin
      line = (580 + l) % V_TOTAL;
      for (int h = 0; h < H_TOTAL; h++) begin
        bus.gpuOe = (h < H_ACTIVE) && (line < V_ACTIVE);
        bus.gpuAddr = ADDR_W'(line * H_ACTIVE + h);
        bus.cpuValid = ($urandom_range(0, 2) == 0);
        bus.cpuAddr = ADDR_W'($urandom_range(0, 31));
        bus.cpuData = DATA_W'($urandom);
        settle(); tick();
      end
    end
    bus.gpuOe = 1'b0; bus.cpuValid = 1'b0;
    repeat (3 * DEPTH + 4) begin
      settle(); tick();
    end
    settle();
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(bus.busy), 32'd0);
    chk("sram_keys", 32'(ram_mem.num()), 32'(exp_mem.num()));
    foreach (exp_mem[a]) begin
      chk("sram_model", ram_mem.exists(a) ? 32'(ram_mem[a]) : 32'hFFFF_FFFF, 32'(exp_mem[a]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
